// File: rtl/branch_resolve_queue.sv
// In-order tracker for gshare predictions awaiting resolution; emits predictor update records.
// Optional accuracy counters are built only when RESOLVE_STATS_EN is defined.
module branch_resolve_queue #(
    parameter int ADDR_W = 11,
    parameter int HIST_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_addr,
    input  logic              pred_taken,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [HIST_W-1:0] upd_index,
    output logic              upd_taken,
    output logic              mispredict,
    output logic [HIST_W-1:0] ghr,
    output logic              underflow,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DEPTH-1:0]  taken_mem_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [HIST_W-1:0] ghr_r;
    logic              upd_valid_r;
    logic [ADDR_W-1:0] upd_addr_r;
    logic [HIST_W-1:0] upd_index_r;
    logic              upd_taken_r;
    logic              mispredict_r;
    logic              underflow_r;

    logic              push_s;
    logic              pop_s;
    logic              miss_s;
    logic              empty_res_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic              head_taken_s;

    // Handshake decode; readiness comes from the registered count only.
    always_comb begin
        head_addr_s  = addr_mem_r[rd_ptr_r];
        head_taken_s = taken_mem_r[rd_ptr_r];
        push_s       = pred_valid && (count_r != FULL_C);
        pop_s        = res_valid && (count_r != {(PTR_W+1){1'b0}});
        empty_res_s  = res_valid && (count_r == {(PTR_W+1){1'b0}});
        if (pop_s) begin
            miss_s = head_taken_s ^ res_taken;
        end else begin
            miss_s = 1'b0;
        end
    end

    // Queue storage, pointers, history and the registered update record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
            end
            taken_mem_r  <= {DEPTH{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {(PTR_W+1){1'b0}};
            ghr_r        <= {HIST_W{1'b0}};
            upd_valid_r  <= 1'b0;
            upd_addr_r   <= {ADDR_W{1'b0}};
            upd_index_r  <= {HIST_W{1'b0}};
            upd_taken_r  <= 1'b0;
            mispredict_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            upd_valid_r <= pop_s;
            underflow_r <= empty_res_s;
            if (pop_s) begin
                upd_addr_r   <= head_addr_s;
                upd_index_r  <= head_addr_s[HIST_W-1:0] ^ ghr_r;
                upd_taken_r  <= res_taken;
                mispredict_r <= miss_s;
                ghr_r        <= {ghr_r[HIST_W-2:0], res_taken};
            end
            if (miss_s) begin
                // Flush: everything younger than the mispredicted branch is wrong-path.
                rd_ptr_r <= wr_ptr_r;
                count_r  <= {(PTR_W+1){1'b0}};
            end else begin
                if (push_s) begin
                    addr_mem_r[wr_ptr_r]  <= pred_addr;
                    taken_mem_r[wr_ptr_r] <= pred_taken;
                    wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                    2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

`ifdef RESOLVE_STATS_EN
    logic [CNT_W-1:0] total_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    // Saturating accuracy counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (pop_s && (total_cnt_r != {CNT_W{1'b1}})) begin
                total_cnt_r <= total_cnt_r + CNT_W'(1);
            end
            if (miss_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + CNT_W'(1);
            end
        end
    end

    assign total_cnt = total_cnt_r;
    assign miss_cnt  = miss_cnt_r;
`else
    assign total_cnt = {CNT_W{1'b0}};
    assign miss_cnt  = {CNT_W{1'b0}};
`endif

    assign pred_ready = (count_r != FULL_C);
    assign upd_valid  = upd_valid_r;
    assign upd_addr   = upd_addr_r;
    assign upd_index  = upd_index_r;
    assign upd_taken  = upd_taken_r;
    assign mispredict = mispredict_r;
    assign ghr        = ghr_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: vector table plus hand-written multi-cycle sequences.
module tb_branch_resolve_queue;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [10:0] pred_addr;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        upd_valid;
    logic [10:0] upd_addr;
    logic [3:0]  upd_index;
    logic        upd_taken;
    logic        mispredict;
    logic [3:0]  ghr;
    logic        underflow;
    logic [3:0]  total_cnt;
    logic [3:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;

    branch_resolve_queue #(.ADDR_W(11), .HIST_W(4), .DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_index(upd_index),
        .upd_taken(upd_taken), .mispredict(mispredict), .ghr(ghr),
        .underflow(underflow), .total_cnt(total_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [10:0] pa;
        logic        pt;
        logic        rv;
        logic        rt;
        logic        e_ready;
        logic        e_uv;
        logic [10:0] e_ua;
        logic [3:0]  e_ui;
        logic        e_ut;
        logic        e_mis;
        logic [3:0]  e_ghr;
        logic        e_uf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        pred_addr  = 11'h000;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
    endtask

    initial begin
        logic [3:0]  g;
        logic [10:0] ea;
        logic        emis;

        vecs[0] = '{1'b1, 11'h005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h005, 4'h5, 1'b1, 1'b0, 4'h1, 1'b0};
        vecs[2] = '{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h005, 4'h5, 1'b1, 1'b0, 4'h1, 1'b0};
        vecs[3] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h005, 4'h5, 1'b1, 1'b0, 4'h1, 1'b1};
        vecs[4] = '{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h005, 4'h5, 1'b1, 1'b0, 4'h1, 1'b0};
        vecs[5] = '{1'b1, 11'h0A3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h005, 4'h5, 1'b1, 1'b0, 4'h1, 1'b0};
        vecs[6] = '{1'b1, 11'h1F0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'h0A3, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0};
        vecs[7] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h1F0, 4'h2, 1'b0, 1'b1, 4'h4, 1'b0};

        reset = 1'b0;
        idle_inputs();
        #2;
        chk("rst_ready", pred_ready, 1'b1);
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_ghr", ghr, 4'h0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_upd_addr", upd_addr, 11'h000);
        step();
        step();
        reset = 1'b1;

        // Vector table: basic push/resolve, empty resolve, simultaneous push+pop, mispredict.
        for (int i = 0; i < 8; i++) begin
            pred_valid = vecs[i].pv;
            pred_addr  = vecs[i].pa;
            pred_taken = vecs[i].pt;
            res_valid  = vecs[i].rv;
            res_taken  = vecs[i].rt;
            step();
            chk($sformatf("v%0d_ready", i), pred_ready, vecs[i].e_ready);
            chk($sformatf("v%0d_upd_valid", i), upd_valid, vecs[i].e_uv);
            chk($sformatf("v%0d_upd_addr", i), upd_addr, vecs[i].e_ua);
            chk($sformatf("v%0d_upd_index", i), upd_index, vecs[i].e_ui);
            chk($sformatf("v%0d_upd_taken", i), upd_taken, vecs[i].e_ut);
            chk($sformatf("v%0d_mispredict", i), mispredict, vecs[i].e_mis);
            chk($sformatf("v%0d_ghr", i), ghr, vecs[i].e_ghr);
            chk($sformatf("v%0d_underflow", i), underflow, vecs[i].e_uf);
        end
        idle_inputs();

        // Fill to full, hold a fifth prediction, then free a slot.
        g = 4'h4;
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_addr  = 11'h010 + 11'(i);
            pred_taken = 1'b0;
            step();
            chk($sformatf("fill%0d_ready", i), pred_ready, (i < 3) ? 1'b1 : 1'b0);
        end
        pred_addr = 11'h014;
        step();
        chk("full_hold_ready", pred_ready, 1'b0);
        chk("full_hold_upd_valid", upd_valid, 1'b0);
        res_valid = 1'b1;
        res_taken = 1'b0;
        step();
        chk("full_pop_upd_valid", upd_valid, 1'b1);
        chk("full_pop_upd_addr", upd_addr, 11'h010);
        chk("full_pop_upd_index", upd_index, 4'h0 ^ g);
        chk("full_pop_ready", pred_ready, 1'b1);
        g = {g[2:0], 1'b0};
        res_valid = 1'b0;
        step();
        chk("held_push_ready", pred_ready, 1'b0);
        chk("held_push_upd_valid", upd_valid, 1'b0);
        pred_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            res_valid = 1'b1;
            res_taken = 1'b0;
            ea = 11'h011 + 11'(j);
            step();
            chk($sformatf("drain%0d_upd_valid", j), upd_valid, 1'b1);
            chk($sformatf("drain%0d_upd_addr", j), upd_addr, ea);
            chk($sformatf("drain%0d_upd_index", j), upd_index, ea[3:0] ^ g);
            g = {g[2:0], 1'b0};
            chk($sformatf("drain%0d_ghr", j), ghr, g);
        end
        idle_inputs();

        // Mispredict flush: B, C and a same-cycle push are discarded.
        pred_valid = 1'b1; pred_addr = 11'h020; pred_taken = 1'b0; step();
        pred_addr = 11'h021; pred_taken = 1'b1; step();
        pred_addr = 11'h022; step();
        pred_addr = 11'h023;
        res_valid = 1'b1;
        res_taken = 1'b1;
        step();
        chk("flush_upd_valid", upd_valid, 1'b1);
        chk("flush_upd_addr", upd_addr, 11'h020);
        chk("flush_mispredict", mispredict, 1'b1);
        chk("flush_upd_taken", upd_taken, 1'b1);
        chk("flush_upd_index", upd_index, 4'h0);
        chk("flush_ghr", ghr, 4'h1);
        chk("flush_ready", pred_ready, 1'b1);
        pred_valid = 1'b0;
        res_taken  = 1'b0;
        step();
        chk("post_flush_underflow", underflow, 1'b1);
        chk("post_flush_upd_valid", upd_valid, 1'b0);
        chk("post_flush_ghr", ghr, 4'h1);
        idle_inputs();

        // Asynchronous reset with three entries queued and an update in flight.
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_addr  = 11'h030 + 11'(i);
            pred_taken = 1'b1;
            step();
        end
        pred_valid = 1'b0;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        step();
        chk("pre_reset_upd_valid", upd_valid, 1'b1);
        chk("pre_reset_ghr", ghr, 4'h3);
        res_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_ready", pred_ready, 1'b1);
        chk("async_rst_ghr", ghr, 4'h0);
        chk("async_rst_upd_valid", upd_valid, 1'b0);
        chk("async_rst_upd_addr", upd_addr, 11'h000);
        chk("async_rst_total", total_cnt, 4'h0);
        step();
        reset = 1'b1;
        res_valid = 1'b1;
        res_taken = 1'b1;
        step();
        chk("post_rst_underflow", underflow, 1'b1);
        chk("post_rst_upd_valid", upd_valid, 1'b0);
        chk("post_rst_ghr", ghr, 4'h0);
        idle_inputs();
        step();

        // Twenty resolves, every fourth one mispredicted.
        for (int i = 0; i < 20; i++) begin
            pred_valid = 1'b1;
            pred_addr  = 11'(i);
            pred_taken = 1'b1;
            step();
            pred_valid = 1'b0;
            emis       = (i % 4 == 0);
            res_valid  = 1'b1;
            res_taken  = ~emis;
            step();
            chk($sformatf("stat%0d_mispredict", i), mispredict, emis);
            res_valid = 1'b0;
        end
        step();
`ifdef RESOLVE_STATS_EN
        chk("total_cnt_sat", total_cnt, 4'hF);
        chk("miss_cnt", miss_cnt, 4'h5);
`else
        chk("total_cnt_off", total_cnt, 4'h0);
        chk("miss_cnt_off", miss_cnt, 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of the gshare predictor and tracks in-flight predictions in order until each branch outcome resolves.
- On resolution it emits a registered update record: address, PHT index, actual outcome and mispredict flag. This record is what trains the predictor's table and history.
- It keeps the committed global history register and, optionally, accuracy counters.

Parameters:
- ADDR_W, 11: branch address width.
- HIST_W, 4: global history width; also the PHT index width.
- DEPTH, 4: number of in-flight prediction entries; must be a power of two and at least 2.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- pred_valid  in  1  a new prediction is presented.
- pred_addr  in  ADDR_W  address of the predicted branch.
- pred_taken  in  1  predictor output for that branch.
- pred_ready  out  1  queue can accept a prediction.
- res_valid  in  1  the oldest in-flight branch has resolved.
- res_taken  in  1  actual outcome of that branch.
- upd_valid  out  1  update record valid; one-cycle pulse.
- upd_addr  out  ADDR_W  address of the resolved branch.
- upd_index  out  HIST_W  PHT index to update.
- upd_taken  out  1  actual outcome.
- mispredict  out  1  stored prediction differs from res_taken; qualified by upd_valid.
- ghr  out  HIST_W  committed global history.
- underflow  out  1  one-cycle pulse: res_valid arrived while the queue was empty.
- total_cnt  out  CNT_W  resolved-branch count (feature only).
- miss_cnt  out  CNT_W  mispredict count (feature only).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, held while reset=0 regardless of clk:
  - queue empty; pred_ready=1
  - ghr=0
  - upd_valid=0, upd_addr=0, upd_index=0, upd_taken=0, mispredict=0, underflow=0
  - counters=0
- Storage: circular FIFO of DEPTH entries {addr, taken}.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - An occupancy counter of log2(DEPTH)+1 bits tracks fill level.
- Push:
  - Occurs when pred_valid && pred_ready.
  - pred_ready = (count != DEPTH), decoded from the registered count only. It does not depend on res_valid in the same cycle.
  - At full, the push is refused even if a pop happens that cycle. The producer must hold pred_valid.
- Pop: occurs when res_valid && count != 0; the oldest entry is consumed.
- Update record, registered with a latency of 1 cycle after the pop edge:
  - upd_valid=1, upd_addr=entry.addr, upd_taken=res_taken.
  - upd_index = entry.addr[HIST_W-1:0] XOR ghr, using ghr as it was before the shift.
  - mispredict = entry.taken XOR res_taken.
- History: on the same pop edge, ghr <= {ghr[HIST_W-2:0], res_taken}.
- Simultaneous push and pop when 0 < count < DEPTH: both happen; count is unchanged.
- Pop with mispredict=1 (flush):
  - All remaining entries are discarded on the same edge: pointers equalise, count=0.
  - A push in that same cycle is also discarded; it is younger speculative work.
  - pred_ready is 1 on the next cycle.
- Empty resolve: res_valid with count==0 gives no pop, no ghr change and upd_valid=0. underflow pulses for 1 cycle.
- Outputs when upd_valid=0: upd_addr, upd_index, upd_taken and mispredict hold their last values.
- Reset mid-operation: all entries are dropped immediately. In-flight resolutions are lost and nothing is emitted.

Optional Feature:
- Macro: RESOLVE_STATS_EN.
- When defined:
  - total_cnt increments on every pop.
  - miss_cnt increments on every pop with mispredict.
  - Both saturate at all-ones and never wrap; both reset to 0.
- When undefined:
  - The counter registers are not built.
  - total_cnt and miss_cnt are driven constant 0.

Test Plan:
1. Reset, then push addr=0x005 with pred_taken=1, then resolve res_taken=1 → next cycle upd_valid=1, upd_addr=0x005, upd_index=0x5, mispredict=0, ghr=0x1.
2. Push 4 entries with no resolves → pred_ready=0 after the 4th. A 5th pred_valid is held without a push. Resolve once → pred_ready=1 next cycle, and the held entry enters on the following edge.
3. Push A(taken=0), B, C; resolve A with res_taken=1 → mispredict=1; count=0 next cycle; B and C are never emitted; ghr shifts in 1.
4. res_valid on an empty queue → underflow pulses 1 cycle; upd_valid=0; ghr unchanged.
5. Drop reset mid-stream with 3 entries queued → pred_ready=1, ghr=0, upd_valid=0 immediately without a clock edge; no stale updates after reset releases.
6. With RESOLVE_STATS_EN, CNT_W=4: run 20 resolves, 5 mispredicted → total_cnt=15 (saturated), miss_cnt=5. Without the macro → both read 0.
